// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding
// for the sequential ALU and its control unit.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iter(
    input logic [3:0] op
  );
    return (op == OP_MULTU) ||
           (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add)
// and restoring divide, one bit per cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             run_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dsh;
  logic [WIDTH:0]   ddif;

  // one iteration step: lo holds multiplier/quotient, hi the partial
  always_comb begin
    msum = {1'b0, hi_q}
         + (lo_q[0] ? {1'b0, b_q} : '0);
    dsh  = {hi_q, lo_q[WIDTH-1]};
    ddif = dsh - {1'b0, b_q};
    hi_d = msum[WIDTH:1];
    lo_d = {msum[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      if (dsh >= {1'b0, b_q}) begin
        hi_d = ddif[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = dsh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // iteration state and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      div_q <= div_i;
      cnt_q <= '0;
      lo_q  <= a_i;
      hi_q  <= '0;
      b_q   <= b_i;
    end else if (run_q) begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

  // done flags the edge that performs the final step
  assign done_o = run_q &&
    (cnt_q == CW'(WIDTH - 1));
  assign lo_o = lo_d;
  assign hi_o = hi_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops inline,
// MULTU/DIVU through the iterative unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             zero_q, ovf_q;
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_ovf;
  logic [WIDTH-1:0] sum, dif;
  logic             go_iter;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign accept  = (state_q == S_IDLE) && start;
  assign go_iter = is_iter(alu_ctrl) &&
    !((alu_ctrl == OP_DIVU) && (B == '0));

  // single-cycle results, incl. divide-by-zero
  always_comb begin
    sum    = A + B;
    dif    = A - B;
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    unique case (alu_ctrl)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                 (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                 (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SLT:  sc_res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: sc_res = WIDTH'(A < B);
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = A;
      end
      default: sc_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .div_i   (alu_ctrl == OP_DIVU),
    .a_i     (A),
    .b_i     (B),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = go_iter ? S_RUN : S_DONE;
      S_RUN:
        if (md_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    md_start = accept && go_iter;
  end

  // result registers update only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else if (accept && !go_iter) begin
      result_q <= sc_res;
      hi_q     <= sc_hi;
      zero_q   <= (sc_res == '0);
      ovf_q    <= sc_ovf;
    end else if ((state_q == S_RUN) && md_done) begin
      result_q <= md_lo;
      hi_q     <= md_hi;
      zero_q   <= (md_lo == '0);
      ovf_q    <= 1'b0;
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32):
// latency, results, start-ignore, reset abort.
module tb_alu_seq;

  localparam int W = 32;
  localparam longint MAXS = 64'sh7FFFFFFF;
  localparam longint MINS = -64'sh80000000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_ctrl = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] result, hi;
  logic         zero, overflow, busy, done;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .A        (A),
    .B        (B),
    .result   (result),
    .hi       (hi),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic exp_t model(
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t e;
    longint sa;
    logic [63:0] p;
    e.res = '0; e.hi = '0; e.ov = 1'b0; e.lat = 1;
    case (op)
      4'b0010: begin
        e.res = a + b;
        sa = longint'($signed(a)) + longint'($signed(b));
        e.ov = (sa > MAXS) || (sa < MINS);
      end
      4'b0110: begin
        e.res = a - b;
        sa = longint'($signed(a)) - longint'($signed(b));
        e.ov = (sa > MAXS) || (sa < MINS);
      end
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0111: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1011: e.res = (a < b) ? 1 : 0;
      4'b1000: begin
        p = 64'(a) * 64'(b);
        e.res = p[31:0];
        e.hi  = p[63:32];
        e.lat = 33;
      end
      4'b1001: begin
        if (b == 0) begin
          e.res = '1;
          e.hi  = a;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
          e.lat = 33;
        end
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic run_op(
    input string nm,
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input int inj
  );
    exp_t e;
    int lat;
    logic seen, busy_ok;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    alu_ctrl = op; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    alu_ctrl = 4'($urandom);
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (start) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
      else if (lat == inj) begin
        alu_ctrl = 4'b0010; A = 32'h1; B = 32'h1;
        start = 1'b1;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (!seen || lat !== e.lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d (seen=%0b)",
               nm, lat, e.lat, seen);
    end
    n_cmp++;
    if (result !== e.res) begin
      n_bad++;
      $display("FAIL %s result: got %h want %h", nm, result, e.res);
    end
    n_cmp++;
    if (hi !== e.hi) begin
      n_bad++;
      $display("FAIL %s hi: got %h want %h", nm, hi, e.hi);
    end
    n_cmp++;
    if (zero !== e.z || overflow !== e.ov) begin
      n_bad++;
      $display("FAIL %s flags: got z=%b ov=%b want z=%b ov=%b",
               nm, zero, overflow, e.z, e.ov);
    end
    n_cmp++;
    if (busy_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy: dropped low before done", nm);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== e.res) begin
      n_bad++;
      $display("FAIL %s after-done: got done=%b busy=%b res=%h want 0 0 %h",
               nm, done, busy, result, e.res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (result !== '0 || hi !== '0 || zero !== 1'b1 ||
        overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got r=%h h=%h z=%b ov=%b b=%b d=%b want 0 0 1 0 0 0",
               result, hi, zero, overflow, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 0);
    run_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 0);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 0);
    run_op("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 0);
  endtask

  task automatic test_logic();
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_1000, 0);
    run_op("nor", 4'b1100, 32'hFFFF_0000, 32'h0000_FFFE, 0);
  endtask

  task automatic test_slt();
    run_op("slt", 4'b0111, 32'hFFFFFFFF, 32'h1, 0);
    run_op("sltu", 4'b1011, 32'hFFFFFFFF, 32'h1, 0);
    run_op("illegal", 4'b1111, 32'h1234, 32'h5678, 0);
  endtask

  task automatic test_multu();
    run_op("multu", 4'b1000, 32'hFFFFFFFF, 32'h2, 0);
    run_op("multu_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_divu();
    run_op("divu", 4'b1001, 32'd100, 32'd7, 0);
    run_op("divu_big", 4'b1001, 32'hFFFFFFFF, 32'h10001, 0);
    run_op("divu_by0", 4'b1001, 32'd5, 32'd0, 0);
  endtask

  task automatic test_start_ignored();
    run_op("multu_inj", 4'b1000, 32'hDEAD_BEEF, 32'h1234_5678, 10);
  endtask

  task automatic test_reset_mid_run();
    logic bad_done;
    bad_done = 1'b0;
    @(negedge clk);
    alu_ctrl = 4'b1000; A = 32'hFFFF_FFFF; B = 32'h3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) bad_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (result !== '0 || hi !== '0 || zero !== 1'b1 ||
        overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: got r=%h h=%h z=%b ov=%b b=%b d=%b want 0 0 1 0 0 0",
               result, hi, zero, overflow, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bad_done = 1'b1;
    end
    n_cmp++;
    if (bad_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_nodone: got activity=1 want 0");
    end
    run_op("multu_post_rst", 4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [9];
    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100,
            4'b0111, 4'b1011, 4'b1000, 4'b1001};
    for (int i = 0; i < 12; i++) begin
      run_op("rand", ops[$urandom_range(0, 8)],
             $urandom, $urandom, 0);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_slt();
    test_multu();
    test_divu();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal values 8 to 64, even).
REQ-002 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port start, input, 1, request; sampled only in IDLE.
REQ-005 Port alu_ctrl, input, 4, operation select; captured with start.
REQ-006 Port A, input, WIDTH, operand A; captured with start.
REQ-007 Port B, input, WIDTH, operand B; captured with start.
REQ-008 Port result, output, WIDTH, primary result (low product / quotient / ALU result).
REQ-009 Port hi, output, WIDTH, secondary result (high product / remainder); 0 for single-cycle ops.
REQ-010 Port zero, output, 1, result equals 0.
REQ-011 Port overflow, output, 1, signed overflow of ADD/SUB; 0 for all other ops.
REQ-012 Port busy, output, 1, high whenever state is not IDLE.
REQ-013 Port done, output, 1, one-cycle pulse; outputs valid from this cycle.

Function
REQ-014 Opcodes SHALL be: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 NOR, 0111 SLT (signed), 1011 SLTU (unsigned), 1000 MULTU, 1001 DIVU; any other code yields result 0, hi 0.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE with start=1: single-cycle op -> DONE; MULTU/DIVU -> RUN with iteration counter cleared.
REQ-017 Single-cycle op: done high in the cycle immediately after the start edge (latency 1).
REQ-018 MULTU: unsigned shift-add, one bit per cycle, WIDTH iterations in RUN; {hi,result} = A*B, 2*WIDTH bits exact.
REQ-019 DIVU: unsigned restoring division, one bit per cycle, WIDTH iterations; result = A/B, hi = A%B.
REQ-020 MULTU/DIVU: done high exactly WIDTH+1 cycles after the start edge.
REQ-021 DIVU with B=0: skip RUN, go directly to DONE; result all-ones, hi = A, latency 1.
REQ-022 DONE SHALL last one cycle, then return to IDLE; start during DONE or RUN SHALL be ignored.
REQ-023 result, hi, zero, overflow SHALL be registered and hold their values until the next accepted start completes; intermediate iteration values SHALL NOT appear on outputs.
REQ-024 ADD/SUB arithmetic modulo 2^WIDTH; overflow per two's-complement sign rule.
REQ-025 zero SHALL reflect only result, not hi.
REQ-026 Operands SHALL be internally latched; A/B/alu_ctrl changes after the start edge have no effect.

Reset
REQ-027 rst_n low SHALL immediately force IDLE; result=0, hi=0, zero=1, overflow=0, busy=0, done=0, counter=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after release behaves as from power-up.

Structure
REQ-029 Opcode constants and the FSM state encoding SHALL reside in shared package alu_pkg, reusable by the control unit.
REQ-030 The iterative multiply/divide datapath SHALL be one sub-module, alu_muldiv_iter, with its own start/done; single-cycle ops remain in alu_seq.

Verification (WIDTH=32)
REQ-031 ADD A=0x7FFFFFFF B=1 -> result 0x80000000, overflow=1, zero=0, done 1 cycle after start.
REQ-032 SUB A=5 B=5 -> result 0, zero=1, overflow=0; SLT A=0xFFFFFFFF B=1 -> 1; SLTU same operands -> 0.
REQ-033 MULTU A=0xFFFFFFFF B=2 -> hi=0x00000001, result=0xFFFFFFFE, done exactly 33 cycles after start, busy high throughout.
REQ-034 DIVU A=100 B=7 -> result 14, hi 2 at cycle 33; DIVU A=5 B=0 -> result 0xFFFFFFFF, hi 5 at cycle 1.
REQ-035 Start MULTU, pulse start with ADD at cycle 10 -> ignored, MULTU result unaffected; assert rst_n=0 at cycle 20 of a second MULTU -> outputs at reset values immediately, no done.
